// File: rtl/serial_rx_fifo_pkg.sv
// Shared constants and types for the UART receive FIFO.
package serial_rx_fifo_pkg;

    localparam int BYTE_W              = 8;
    localparam int DEFAULT_DEPTH       = 16;
    localparam int DEFAULT_ADDR_W      = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Whether the receiver's post-reset idle edge has already been seen.
    typedef enum logic {
        ARM_WAIT   = 1'b0,
        ARM_ACTIVE = 1'b1
    } arm_state_t;

endpackage

// File: rtl/serial_rx_fifo_sync_edge_detect.sv
// Resynchronises the receiver ready status, detects its rising edge and
// swallows the first edge after reset (the receiver leaving reset, no byte).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARM_WAIT   | reset seen; next ready edge is the receiver coming out of reset
// ARM_ACTIVE | every ready edge marks a freshly loaded byte
module sync_edge_detect
    import serial_rx_fifo_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_rdy_async,
    output logic o_push_evt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rdy_d;
    arm_state_t             r_state;
    arm_state_t             w_state_nxt;
    logic                   w_rdy_s;
    logic                   w_edge;

    assign w_rdy_s = r_sync[SYNC_STAGES-1];
    assign w_edge  = w_rdy_s & ~r_rdy_d;

    // Synchroniser chain plus one delay flop for edge detection.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_sync  <= '0;
            r_rdy_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_rdy_async};
            r_rdy_d <= w_rdy_s;
        end
    end

    // Armed state register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= ARM_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Discard the first edge, pass every later edge through as a push.
    always_comb begin
        w_state_nxt = r_state;
        o_push_evt  = 1'b0;
        case (r_state)
            ARM_WAIT: begin
                if (w_edge) begin
                    w_state_nxt = ARM_ACTIVE;
                end
            end
            ARM_ACTIVE: begin
                o_push_evt = w_edge;
            end
            default: begin
                w_state_nxt = ARM_WAIT;
            end
        endcase
    end

endmodule

// File: rtl/serial_rx_fifo.sv
// Byte FIFO behind the UART receive stage: captures each completed byte and
// hands it to the host through a valid/pop handshake with sticky overflow.
module serial_rx_fifo
    import serial_rx_fifo_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [BYTE_W-1:0] IN_RX_DATA,
    input  logic              IN_RX_READY,
    input  logic              IN_POP,
    input  logic              IN_CLEAR_OVF,
    output logic [BYTE_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    output logic [ADDR_W:0]   OUT_COUNT,
    output logic              OUT_FULL,
    output logic              OUT_OVERFLOW
);

    localparam logic [ADDR_W:0] L_FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [BYTE_W-1:0] r_out_data;
    logic              r_overflow;

    logic              w_push_evt;
    logic              w_full;
    logic              w_empty;
    logic              w_pop_acc;
    logic              w_push_acc;
    logic              w_ovf_set;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_count_nxt;
    logic [BYTE_W-1:0] w_head_nxt;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .i_rdy_async (IN_RX_READY),
        .o_push_evt  (w_push_evt)
    );

    assign w_full     = (r_count == L_FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_pop_acc  = IN_POP & ~w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push_acc = w_push_evt & (~w_full | w_pop_acc);
    assign w_ovf_set  = w_push_evt & w_full & ~w_pop_acc;

    assign w_rd_ptr_nxt = w_pop_acc ? (r_rd_ptr + 1'b1) : r_rd_ptr;

    // Next fill level from the accepted push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // The incoming byte becomes the head when it lands on the next read slot,
    // so the registered head is correct in the same cycle OUT_VALID rises.
    assign w_head_nxt = (w_push_acc && (r_wr_ptr == w_rd_ptr_nxt)) ? IN_RX_DATA
                                                                   : r_mem[w_rd_ptr_nxt];

    // Storage array write port; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= IN_RX_DATA;
        end
    end

    // Pointers, fill count, registered head byte and sticky overflow.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if ((w_push_acc || w_pop_acc) && (w_count_nxt != '0)) begin
                r_out_data <= w_head_nxt;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (IN_CLEAR_OVF) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign OUT_DATA     = r_out_data;
    assign OUT_VALID    = ~w_empty;
    assign OUT_COUNT    = r_count;
    assign OUT_FULL     = w_full;
    assign OUT_OVERFLOW = r_overflow;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Self-checking bench for serial_rx_fifo against a queue-based reference.
module tb_serial_rx_fifo;

    localparam int DEPTH = 16;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] IN_RX_DATA;
    logic       IN_RX_READY;
    logic       IN_POP;
    logic       IN_CLEAR_OVF;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic [4:0] OUT_COUNT;
    logic       OUT_FULL;
    logic       OUT_OVERFLOW;

    int         total = 0;
    int         bad   = 0;

    logic [7:0] q[$];
    bit         armed;
    bit         ovf_m;
    logic [7:0] last_out;

    serial_rx_fifo #(
        .DEPTH       (DEPTH),
        .ADDR_W      (4),
        .SYNC_STAGES (2)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .IN_RX_DATA   (IN_RX_DATA),
        .IN_RX_READY  (IN_RX_READY),
        .IN_POP       (IN_POP),
        .IN_CLEAR_OVF (IN_CLEAR_OVF),
        .OUT_DATA     (OUT_DATA),
        .OUT_VALID    (OUT_VALID),
        .OUT_COUNT    (OUT_COUNT),
        .OUT_FULL     (OUT_FULL),
        .OUT_OVERFLOW (OUT_OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Receiver delivers one byte: busy (ready low), then loads data and goes idle.
    // pop/clr are asserted only for the clock edge where the byte is pushed.
    // Model: first edge after reset is discarded; otherwise an accepted pop
    // happens first, then the byte goes in if there is room, else it is lost.
    task automatic rx_edge(input logic [7:0] b, input int low_cyc, input bit pop, input bit clr);
        bit full_now;
        IN_RX_READY = 1'b0;
        repeat (low_cyc) @(negedge CLK);
        IN_RX_DATA  = b;
        IN_RX_READY = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        IN_POP       = pop;
        IN_CLEAR_OVF = clr;
        @(negedge CLK);
        IN_POP       = 1'b0;
        IN_CLEAR_OVF = 1'b0;
        repeat (3) @(negedge CLK);
        if (!armed) begin
            armed = 1'b1;
            if (pop && q.size() > 0) last_out = q.pop_front();
            if (clr) ovf_m = 1'b0;
        end else begin
            if (pop && q.size() > 0) last_out = q.pop_front();
            full_now = (q.size() >= DEPTH);
            if (!full_now) q.push_back(b);
            if (full_now) ovf_m = 1'b1;
            else if (clr) ovf_m = 1'b0;
        end
    endtask

    task automatic pop_one();
        IN_POP = 1'b1;
        @(negedge CLK);
        IN_POP = 1'b0;
        if (q.size() > 0) last_out = q.pop_front();
    endtask

    task automatic clear_ovf();
        IN_CLEAR_OVF = 1'b1;
        @(negedge CLK);
        IN_CLEAR_OVF = 1'b0;
        ovf_m = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", OUT_VALID); end
        total++; if (OUT_COUNT !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", OUT_COUNT); end
        total++; if (OUT_DATA !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", OUT_DATA); end
        total++; if (OUT_FULL !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", OUT_FULL); end
        total++; if (OUT_OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", OUT_OVERFLOW); end
    endtask

    task automatic test_startup_discard();
        RESET_N = 1'b1;
        rx_edge(8'hEE, 16, 1'b0, 1'b0);
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL startup_valid got=%b exp=0", OUT_VALID); end
        total++; if (OUT_COUNT !== 5'd0) begin bad++; $display("FAIL startup_count got=%0d exp=0", OUT_COUNT); end
    endtask

    task automatic test_latency();
        IN_RX_READY = 1'b0;
        repeat (8) @(negedge CLK);
        IN_RX_DATA  = 8'h77;
        IN_RX_READY = 1'b1;
        @(negedge CLK);
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL lat_cyc1_valid got=%b exp=0", OUT_VALID); end
        @(negedge CLK);
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL lat_cyc2_valid got=%b exp=0", OUT_VALID); end
        @(negedge CLK);
        total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL lat_cyc3_valid got=%b exp=1", OUT_VALID); end
        total++; if (OUT_DATA !== 8'h77) begin bad++; $display("FAIL lat_cyc3_data got=%h exp=77", OUT_DATA); end
        repeat (3) @(negedge CLK);
        q.push_back(8'h77);
        pop_one();
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL lat_drain_valid got=%b exp=0", OUT_VALID); end
    endtask

    task automatic test_three_bytes();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'h01;
        for (int i = 0; i < 3; i++) rx_edge(exp_b[i], 8, 1'b0, 1'b0);
        total++; if (OUT_COUNT !== 5'd3) begin bad++; $display("FAIL three_count got=%0d exp=3", OUT_COUNT); end
        IN_POP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (OUT_DATA !== exp_b[i]) begin bad++; $display("FAIL three_data%0d got=%h exp=%h", i, OUT_DATA, exp_b[i]); end
            total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL three_valid%0d got=%b exp=1", i, OUT_VALID); end
            @(negedge CLK);
            last_out = q.pop_front();
        end
        IN_POP = 1'b0;
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL three_empty_valid got=%b exp=0", OUT_VALID); end
        total++; if (OUT_COUNT !== 5'd0) begin bad++; $display("FAIL three_empty_count got=%0d exp=0", OUT_COUNT); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) rx_edge(8'(i), 8, 1'b0, 1'b0);
        total++; if (OUT_FULL !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", OUT_FULL); end
        total++; if (OUT_COUNT !== 5'd16) begin bad++; $display("FAIL ovf_count16 got=%0d exp=16", OUT_COUNT); end
        total++; if (OUT_OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", OUT_OVERFLOW); end
        rx_edge(8'h10, 8, 1'b0, 1'b0);
        total++; if (OUT_OVERFLOW !== ovf_m) begin bad++; $display("FAIL ovf_set got=%b exp=%b", OUT_OVERFLOW, ovf_m); end
        total++; if (OUT_COUNT !== 5'd16) begin bad++; $display("FAIL ovf_count_kept got=%0d exp=16", OUT_COUNT); end
        // Overflow set and clear in the same cycle: set must win.
        clear_ovf();
        total++; if (OUT_OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", OUT_OVERFLOW); end
        rx_edge(8'h11, 8, 1'b0, 1'b1);
        total++; if (OUT_OVERFLOW !== ovf_m) begin bad++; $display("FAIL ovf_set_wins got=%b exp=%b", OUT_OVERFLOW, ovf_m); end
        for (int i = 0; i < 16; i++) begin
            total++; if (OUT_DATA !== q[0]) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, OUT_DATA, q[0]); end
            pop_one();
        end
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL ovf_drained_valid got=%b exp=0", OUT_VALID); end
        clear_ovf();
    endtask

    task automatic test_simul_full();
        logic [7:0] nb;
        for (int i = 0; i < 16; i++) rx_edge(8'($urandom_range(0, 255)), 8, 1'b0, 1'b0);
        nb = 8'hD7;
        rx_edge(nb, 8, 1'b1, 1'b0);
        total++; if (OUT_COUNT !== 5'd16) begin bad++; $display("FAIL simul_count got=%0d exp=16", OUT_COUNT); end
        total++; if (OUT_OVERFLOW !== 1'b0) begin bad++; $display("FAIL simul_ovf got=%b exp=0", OUT_OVERFLOW); end
        for (int i = 0; i < 16; i++) begin
            total++; if (OUT_DATA !== q[0]) begin bad++; $display("FAIL simul_drain%0d got=%h exp=%h", i, OUT_DATA, q[0]); end
            pop_one();
        end
        total++; if (last_out !== nb) begin bad++; $display("FAIL simul_last_model got=%h exp=%h", last_out, nb); end
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL simul_empty got=%b exp=0", OUT_VALID); end
    endtask

    task automatic test_pop_empty();
        for (int i = 0; i < 3; i++) pop_one();
        total++; if (OUT_COUNT !== 5'd0) begin bad++; $display("FAIL popempty_count got=%0d exp=0", OUT_COUNT); end
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL popempty_valid got=%b exp=0", OUT_VALID); end
        total++; if (OUT_DATA !== last_out) begin bad++; $display("FAIL popempty_hold got=%h exp=%h", OUT_DATA, last_out); end
        rx_edge(8'h5A, 8, 1'b0, 1'b0);
        total++; if (OUT_DATA !== 8'h5A) begin bad++; $display("FAIL popempty_5a got=%h exp=5a", OUT_DATA); end
        total++; if (OUT_COUNT !== 5'd1) begin bad++; $display("FAIL popempty_cnt1 got=%0d exp=1", OUT_COUNT); end
        pop_one();
    endtask

    task automatic test_random();
        int op;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            if (op < 6) rx_edge(8'($urandom_range(0, 255)), $urandom_range(4, 10), 1'b0, 1'b0);
            else if (op < 9) repeat ($urandom_range(1, 3)) pop_one();
            else clear_ovf();
            total++; if (OUT_COUNT !== 5'(q.size())) begin bad++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, OUT_COUNT, q.size()); end
            total++; if (OUT_OVERFLOW !== ovf_m) begin bad++; $display("FAIL rnd_ovf it=%0d got=%b exp=%b", it, OUT_OVERFLOW, ovf_m); end
            total++; if (OUT_FULL !== (q.size() == DEPTH)) begin bad++; $display("FAIL rnd_full it=%0d got=%b exp=%b", it, OUT_FULL, q.size() == DEPTH); end
            if (q.size() > 0) begin
                total++; if (OUT_DATA !== q[0]) begin bad++; $display("FAIL rnd_data it=%0d got=%h exp=%h", it, OUT_DATA, q[0]); end
            end else begin
                total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL rnd_valid it=%0d got=%b exp=0", it, OUT_VALID); end
            end
        end
    endtask

    task automatic test_mid_reset();
        while (q.size() > 0) pop_one();
        for (int i = 0; i < 5; i++) rx_edge(8'($urandom_range(0, 255)), 8, 1'b0, 1'b0);
        total++; if (OUT_COUNT !== 5'd5) begin bad++; $display("FAIL midrst_pre_count got=%0d exp=5", OUT_COUNT); end
        RESET_N     = 1'b0;
        IN_RX_READY = 1'b0;
        @(negedge CLK);
        q.delete();
        armed    = 1'b0;
        ovf_m    = 1'b0;
        last_out = 8'h00;
        total++; if (OUT_COUNT !== 5'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", OUT_COUNT); end
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", OUT_VALID); end
        total++; if (OUT_DATA !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", OUT_DATA); end
        total++; if (OUT_OVERFLOW !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b exp=0", OUT_OVERFLOW); end
        RESET_N = 1'b1;
        rx_edge(8'h99, 8, 1'b0, 1'b0);
        total++; if (OUT_COUNT !== 5'd0) begin bad++; $display("FAIL midrst_discard got=%0d exp=0", OUT_COUNT); end
        rx_edge(8'hC3, 8, 1'b0, 1'b0);
        total++; if (OUT_COUNT !== 5'd1) begin bad++; $display("FAIL midrst_c3_count got=%0d exp=1", OUT_COUNT); end
        total++; if (OUT_DATA !== 8'hC3) begin bad++; $display("FAIL midrst_c3_data got=%h exp=c3", OUT_DATA); end
    endtask

    initial begin
        RESET_N      = 1'b0;
        IN_RX_DATA   = 8'h00;
        IN_RX_READY  = 1'b0;
        IN_POP       = 1'b0;
        IN_CLEAR_OVF = 1'b0;
        armed        = 1'b0;
        ovf_m        = 1'b0;
        last_out     = 8'h00;
        repeat (3) @(negedge CLK);
        test_reset();
        test_startup_discard();
        test_latency();
        test_three_bytes();
        test_overflow();
        test_simul_full();
        test_pop_empty();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
